// File: rtl/bike_pkg.sv
// Shared types and defaults for the bike computer arithmetic blocks.
// Holds divider FSM states, requester ids and default operand widths.
package bike_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic REQ_SPEED = 1'b0;
    localparam logic REQ_AVG   = 1'b1;

    localparam int unsigned DEFAULT_DIVIDEND_WIDTH = 16;
    localparam int unsigned DEFAULT_DIVISOR_WIDTH  = 16;
    localparam int unsigned DEFAULT_QUOT_WIDTH     = 12;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in one dividend bit,
// subtract the divisor when the trial remainder is non-negative.
module div_step #(
    parameter int unsigned DIVISOR_WIDTH = bike_pkg::DEFAULT_DIVISOR_WIDTH
) (
    input  logic [DIVISOR_WIDTH:0]   rem_in,
    input  logic [DIVISOR_WIDTH-1:0] divisor,
    input  logic                     bit_in,
    output logic [DIVISOR_WIDTH:0]   rem_out,
    output logic                     q_bit
);

    localparam int unsigned RW = DIVISOR_WIDTH + 1;

    always_comb begin
        q_bit   = ({rem_in, bit_in} >= {2'b00, divisor});
        rem_out = q_bit ? RW'({rem_in, bit_in} - {2'b00, divisor})
                        : RW'({rem_in, bit_in});
    end

endmodule

// File: rtl/shared_divider.sv
// Round-robin shared sequential restoring divider for the speed and
// average-speed initiators; one quotient bit per clock, tagged ready pulse.
module shared_divider #(
    parameter int unsigned DIVIDEND_WIDTH = bike_pkg::DEFAULT_DIVIDEND_WIDTH,
    parameter int unsigned DIVISOR_WIDTH  = bike_pkg::DEFAULT_DIVISOR_WIDTH,
    parameter int unsigned QUOT_WIDTH     = bike_pkg::DEFAULT_QUOT_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start0,
    input  logic [DIVIDEND_WIDTH-1:0] dividend0,
    input  logic [DIVISOR_WIDTH-1:0]  divisor0,
    input  logic                      start1,
    input  logic [DIVIDEND_WIDTH-1:0] dividend1,
    input  logic [DIVISOR_WIDTH-1:0]  divisor1,
    output logic                      busy,
    output logic                      ready,
    output logic                      ready_sel,
    output logic [QUOT_WIDTH-1:0]     quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      overflow,
    output logic                      div_zero
);
    import bike_pkg::*;

    localparam int unsigned CW = $clog2(DIVIDEND_WIDTH + 1);
    localparam logic [CW-1:0] COUNT_LOAD = CW'(DIVIDEND_WIDTH);

    div_state_t state;
    logic pend0, pend1, last_served, owner;
    logic [DIVIDEND_WIDTH-1:0] dq_sr;
    logic [DIVISOR_WIDTH-1:0]  dvs;
    logic [DIVISOR_WIDTH:0]    part_rem, step_rem;
    logic                      step_qbit;
    logic [CW-1:0]             count;

    logic req0, req1, accept, accept_id, accept0, accept1, quot_ovf;
    logic [DIVIDEND_WIDTH-1:0] acc_dividend, full_quot;
    logic [DIVISOR_WIDTH-1:0]  acc_divisor;

    div_step #(.DIVISOR_WIDTH(DIVISOR_WIDTH)) u_step (
        .rem_in  (part_rem),
        .divisor (dvs),
        .bit_in  (dq_sr[DIVIDEND_WIDTH-1]),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    always_comb begin
        req0   = pend0 | start0;
        req1   = pend1 | start1;
        accept = (state == IDLE) && (req0 || req1);
        if (req0 && req1)
            accept_id = ~last_served;
        else if (req1)
            accept_id = REQ_AVG;
        else
            accept_id = REQ_SPEED;
        accept0      = accept && (accept_id == REQ_SPEED);
        accept1      = accept && (accept_id == REQ_AVG);
        acc_dividend = (accept_id == REQ_AVG) ? dividend1 : dividend0;
        acc_divisor  = (accept_id == REQ_AVG) ? divisor1 : divisor0;
        // Dividend bits leave at the top while quotient bits enter at the bottom.
        full_quot = {dq_sr[DIVIDEND_WIDTH-2:0], step_qbit};
        quot_ovf  = |full_quot[DIVIDEND_WIDTH-1:QUOT_WIDTH];
    end

    assign busy  = (state != IDLE);
    assign ready = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pend0       <= 1'b0;
            pend1       <= 1'b0;
            last_served <= 1'b1;
            owner       <= 1'b0;
            dq_sr       <= '0;
            dvs         <= '0;
            part_rem    <= '0;
            count       <= '0;
            ready_sel   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_zero    <= 1'b0;
        end else begin
            // A start coinciding with acceptance survives only if it re-requests.
            pend0 <= accept0 ? (pend0 & start0) : (pend0 | start0);
            pend1 <= accept1 ? (pend1 & start1) : (pend1 | start1);
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_served <= accept_id;
                        owner       <= accept_id;
                        dq_sr       <= acc_dividend;
                        dvs         <= acc_divisor;
                        part_rem    <= '0;
                        count       <= COUNT_LOAD;
                        if (acc_divisor == '0) begin
                            state     <= DONE;
                            ready_sel <= accept_id;
                            quotient  <= '1;
                            remainder <= '0;
                            overflow  <= 1'b0;
                            div_zero  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    part_rem <= step_rem;
                    dq_sr    <= full_quot;
                    count    <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state     <= DONE;
                        ready_sel <= owner;
                        quotient  <= quot_ovf ? '1 : full_quot[QUOT_WIDTH-1:0];
                        remainder <= step_rem[DIVISOR_WIDTH-1:0];
                        overflow  <= quot_ovf;
                        div_zero  <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_divider.sv
// Directed bench for shared_divider: single, overflow, divide-by-zero,
// collision/alternation, mid-run reset and re-request scenarios.
module tb_shared_divider;

    logic        clock = 1'b0;
    logic        reset, start0, start1;
    logic [15:0] dividend0, divisor0, dividend1, divisor1;
    logic        busy, ready, ready_sel, overflow, div_zero;
    logic [11:0] quotient;
    logic [15:0] remainder;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    shared_divider #(
        .DIVIDEND_WIDTH(16),
        .DIVISOR_WIDTH (16),
        .QUOT_WIDTH    (12)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start0   (start0),
        .dividend0(dividend0),
        .divisor0 (divisor0),
        .start1   (start1),
        .dividend1(dividend1),
        .divisor1 (divisor1),
        .busy     (busy),
        .ready    (ready),
        .ready_sel(ready_sel),
        .quotient (quotient),
        .remainder(remainder),
        .overflow (overflow),
        .div_zero (div_zero)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advances until ready is seen; cyc is the cycle index relative to the accept edge, -1 on timeout.
    task automatic wait_ready(input int first, input int limit, output int cyc);
        cyc = first;
        while (ready !== 1'b1 && cyc < limit) begin
            tick();
            cyc++;
        end
        if (ready !== 1'b1) cyc = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        total++; if (ready_sel !== 1'b0) begin bad++; $display("FAIL reset_sel: got %b want 0", ready_sel); end
        total++; if (quotient !== 12'd0) begin bad++; $display("FAIL reset_quot: got %0d want 0", quotient); end
        total++; if (remainder !== 16'd0) begin bad++; $display("FAIL reset_rem: got %0d want 0", remainder); end
        total++; if (overflow !== 1'b0 || div_zero !== 1'b0) begin
            bad++; $display("FAIL reset_flags: got ov=%b dz=%b want 0 0", overflow, div_zero);
        end
    endtask

    task automatic test_single();
        int cyc;
        dividend0 = 16'd3600; divisor0 = 16'd7; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
        wait_ready(1, 40, cyc);
        total++; if (cyc != 17) begin bad++; $display("FAIL single_latency: got %0d want 17", cyc); end
        total++; if (ready_sel !== 1'b0) begin bad++; $display("FAIL single_sel: got %b want 0", ready_sel); end
        total++; if (quotient !== 12'd514) begin bad++; $display("FAIL single_quot: got %0d want 514", quotient); end
        total++; if (remainder !== 16'd2) begin bad++; $display("FAIL single_rem: got %0d want 2", remainder); end
        total++; if (overflow !== 1'b0 || div_zero !== 1'b0) begin
            bad++; $display("FAIL single_flags: got ov=%b dz=%b want 0 0", overflow, div_zero);
        end
        tick();
        total++; if (ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_pulse: got ready=%b busy=%b want 0 0", ready, busy);
        end
        total++; if (quotient !== 12'd514) begin bad++; $display("FAIL single_hold: got %0d want 514", quotient); end
    endtask

    task automatic test_overflow();
        int cyc;
        dividend1 = 16'd60000; divisor1 = 16'd3; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_ready(1, 40, cyc);
        total++; if (cyc != 17) begin bad++; $display("FAIL ovf_latency: got %0d want 17", cyc); end
        total++; if (ready_sel !== 1'b1) begin bad++; $display("FAIL ovf_sel: got %b want 1", ready_sel); end
        total++; if (quotient !== 12'd4095) begin bad++; $display("FAIL ovf_quot: got %0d want 4095", quotient); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        total++; if (remainder !== 16'd0) begin bad++; $display("FAIL ovf_rem: got %0d want 0", remainder); end
        tick();
    endtask

    task automatic test_div0();
        int cyc;
        dividend0 = 16'd1000; divisor0 = 16'd0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL div0_busy: got %b want 1", busy); end
        wait_ready(1, 40, cyc);
        total++; if (cyc != 1) begin bad++; $display("FAIL div0_latency: got %0d want 1", cyc); end
        total++; if (div_zero !== 1'b1 || overflow !== 1'b0) begin
            bad++; $display("FAIL div0_flags: got dz=%b ov=%b want 1 0", div_zero, overflow);
        end
        total++; if (quotient !== 12'd4095) begin bad++; $display("FAIL div0_quot: got %0d want 4095", quotient); end
        total++; if (remainder !== 16'd0) begin bad++; $display("FAIL div0_rem: got %0d want 0", remainder); end
        total++; if (ready_sel !== 1'b0) begin bad++; $display("FAIL div0_sel: got %b want 0", ready_sel); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL div0_busy_len: got %b want 0", busy); end
    endtask

    task automatic test_collision();
        int cyc;
        do_reset();
        dividend0 = 16'd100; divisor0 = 16'd10;
        dividend1 = 16'd200; divisor1 = 16'd10;
        for (int round = 0; round < 2; round++) begin
            start0 = 1'b1; start1 = 1'b1;
            tick();
            start0 = 1'b0; start1 = 1'b0;
            wait_ready(1, 40, cyc);
            total++; if (cyc != 17) begin bad++; $display("FAIL coll%0d_first_latency: got %0d want 17", round, cyc); end
            total++; if (ready_sel !== 1'b0) begin bad++; $display("FAIL coll%0d_first_sel: got %b want 0", round, ready_sel); end
            total++; if (quotient !== 12'd10) begin bad++; $display("FAIL coll%0d_first_quot: got %0d want 10", round, quotient); end
            tick();
            wait_ready(18, 60, cyc);
            total++; if (cyc != 35) begin bad++; $display("FAIL coll%0d_second_latency: got %0d want 35", round, cyc); end
            total++; if (ready_sel !== 1'b1) begin bad++; $display("FAIL coll%0d_second_sel: got %b want 1", round, ready_sel); end
            total++; if (quotient !== 12'd20 || remainder !== 16'd0) begin
                bad++; $display("FAIL coll%0d_second_result: got q=%0d r=%0d want 20 0", round, quotient, remainder);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int pulses = 0;
        dividend0 = 16'd3600; divisor0 = 16'd7; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (7) begin
            if (ready === 1'b1) pulses++;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (quotient !== 12'd0) begin bad++; $display("FAIL midrst_quot: got %0d want 0", quotient); end
        repeat (20) begin
            if (ready === 1'b1) pulses++;
            tick();
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL midrst_no_ready: got %0d pulses want 0", pulses); end
        dividend1 = 16'd9; divisor1 = 16'd2; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_ready(1, 40, cyc);
        total++; if (cyc != 17) begin bad++; $display("FAIL midrst_latency: got %0d want 17", cyc); end
        total++; if (ready_sel !== 1'b1 || quotient !== 12'd4 || remainder !== 16'd1) begin
            bad++; $display("FAIL midrst_result: got sel=%b q=%0d r=%0d want 1 4 1", ready_sel, quotient, remainder);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        dividend0 = 16'd3600; divisor0 = 16'd7; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (4) tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_ready(6, 40, cyc);
        total++; if (cyc != 17) begin bad++; $display("FAIL b2b_first_latency: got %0d want 17", cyc); end
        total++; if (ready_sel !== 1'b0 || quotient !== 12'd514) begin
            bad++; $display("FAIL b2b_first_result: got sel=%b q=%0d want 0 514", ready_sel, quotient);
        end
        tick();
        wait_ready(18, 60, cyc);
        total++; if (cyc != 35) begin bad++; $display("FAIL b2b_second_latency: got %0d want 35", cyc); end
        total++; if (ready_sel !== 1'b0 || quotient !== 12'd514 || remainder !== 16'd2) begin
            bad++; $display("FAIL b2b_second_result: got sel=%b q=%0d r=%0d want 0 514 2", ready_sel, quotient, remainder);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        dividend0 = '0; divisor0 = '0; dividend1 = '0; divisor1 = '0;
        test_reset();
        test_single();
        test_overflow();
        test_div0();
        test_collision();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
